shift_sequencer: RTL and testbench

- Multicycle shift unit for the CPU execute stage.
- Performs SLL/SRL/SRA/ROL on a 32-bit operand by reusing one power-of-two shift stage per cycle, MSB amount bit first (16, 8, 4, 2, 1).
- Trades area for latency versus the single-cycle barrel shifter.
- Uses the same start/result-ready handshake style as the multiply/divide unit, so the pipeline stall logic can treat both identically.

---
 rtl/shift_sequencer.sv | 94 +++++++++
 tb/tb_shift_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multicycle SLL/SRL/SRA/ROL applying one power-of-two stage per cycle (16,8,4,2,1).
// Define SHIFT_SEQ_EARLY_EXIT_EN to complete as soon as no lower amount bits remain.
module shift_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [AMT_WIDTH-1:0]  shift_amt,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_resultRDY,
  output logic                  busy
);
  if (2**AMT_WIDTH != DATA_WIDTH) begin : g_bad_width
    $error("shift_sequencer: 2**AMT_WIDTH must equal DATA_WIDTH");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t                  state_q, state_d;
  logic [AMT_WIDTH-1:0]    stage_q, stage_d, amt_q, amt_d;
  logic [1:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d, result_q, result_d, shifted;
  logic                    sign_q, sign_d, rdy_q, rdy_d, done;
  logic [2*DATA_WIDTH-1:0] wide;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      amt_q    <= '0;
      op_q     <= '0;
      work_q   <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      amt_q    <= amt_d;
      op_q     <= op_d;
      work_q   <= work_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
    end
  end
  // stage_q is one-hot and its value is the current stage's shift distance
  always_comb begin
    wide = op_q == 2'b11 ? {work_q, work_q} << stage_q
         : op_q == 2'b10 ? {{DATA_WIDTH{sign_q}}, work_q} >> stage_q
         : op_q == 2'b01 ? {{DATA_WIDTH{1'b0}}, work_q} >> stage_q
         : {{DATA_WIDTH{1'b0}}, work_q} << stage_q;
    shifted = op_q == 2'b11 ? wide[2*DATA_WIDTH-1:DATA_WIDTH] : wide[DATA_WIDTH-1:0];
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    done = (amt_q & (stage_q - AMT_WIDTH'(1))) == '0;
`else
    done = stage_q[0];
`endif
  end
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    amt_d    = amt_q;
    op_d     = op_q;
    work_d   = work_q;
    sign_d   = sign_q;
    result_d = result_q;
    rdy_d    = 1'b0;
    if (state_q == IDLE) begin
      if (ctrl_start) begin
        state_d = RUN;
        stage_d = {1'b1, {(AMT_WIDTH-1){1'b0}}};
        amt_d   = shift_amt;
        op_d    = op;
        work_d  = data_in;
        sign_d  = data_in[DATA_WIDTH-1];
      end
    end else begin
      work_d  = |(amt_q & stage_q) ? shifted : work_q;
      stage_d = stage_q >> 1;
      if (done) begin
        state_d  = IDLE;
        result_d = work_d;
        rdy_d    = 1'b1;
      end
    end
  end
  always_comb begin
    busy           = state_q == RUN;
    data_result    = result_q;
    data_resultRDY = rdy_q;
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vector table plus multi-cycle corner sequences for shift_sequencer.
module tb_shift_sequencer;
  logic        clock = 1'b0, reset = 1'b1, ctrl_start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] data_in = '0, data_result;
  logic [4:0]  shift_amt = '0;
  logic        data_resultRDY, busy;
  int          tests = 0, fails = 0;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROL = 2'b11;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] din;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];
  shift_sequencer dut (
    .clock(clock), .reset(reset), .ctrl_start(ctrl_start), .op(op),
    .data_in(data_in), .shift_amt(shift_amt), .data_result(data_result),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic int exp_lat(input logic [4:0] a);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    int ai = int'(a);
    for (int j = 4; j >= 0; j--)
      if ((ai % (1 << j)) == 0) return 5 - j;
    return 5;
`else
    return 5;
`endif
  endfunction
  task automatic kick(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a);
    @(negedge clock);
    op = o; data_in = d; shift_amt = a; ctrl_start = 1'b1;
    @(negedge clock);
    ctrl_start = 1'b0; op = ~o; data_in = ~d; shift_amt = ~a;
  endtask
  task automatic wait_rdy(input int n0, output int n);
    n = n0;
    while (!data_resultRDY && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] a, input logic [31:0] exp);
    int n;
    kick(o, d, a);
    chk({name, " busy"}, {31'd0, busy}, 32'd1);
    wait_rdy(0, n);
    chk({name, " latency"}, n, exp_lat(a));
    chk({name, " result"}, data_result, exp);
    chk({name, " idle"}, {31'd0, busy}, 32'd0);
    @(negedge clock);
    chk({name, " rdy pulse"}, {31'd0, data_resultRDY}, 32'd0);
    chk({name, " hold"}, data_result, exp);
  endtask
  initial begin
    int n, seen;
    vecs[0]  = '{SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{SRA, 32'h8000_00F0, 5'd4,  32'hF800_000F};
    vecs[2]  = '{SRL, 32'h8000_00F0, 5'd4,  32'h0800_000F};
    vecs[3]  = '{ROL, 32'h8000_0001, 5'd1,  32'h0000_0003};
    vecs[4]  = '{SLL, 32'h0000_00FF, 5'd8,  32'h0000_FF00};
    vecs[5]  = '{SLL, 32'h0000_ABCD, 5'd16, 32'hABCD_0000};
    vecs[6]  = '{SRL, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[7]  = '{ROL, 32'h1234_5678, 5'd8,  32'h3456_7812};
    vecs[8]  = '{SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[9]  = '{SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[10] = '{ROL, 32'h8000_0000, 5'd31, 32'h4000_0000};
    vecs[11] = '{SRL, 32'hFFFF_FFFF, 5'd17, 32'h0000_7FFF};
    vecs[12] = '{SLL, 32'h1234_5678, 5'd5,  32'h468A_CF00};
    vecs[13] = '{SRA, 32'h8000_0000, 5'd1,  32'hC000_0000};
    vecs[14] = '{ROL, 32'hABCD_1234, 5'd16, 32'h1234_ABCD};
    repeat (2) @(negedge clock);
    chk("reset result", data_result, 32'h0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].amt, vecs[i].exp);
    // start while busy must be dropped, not queued
    kick(ROL, 32'h8000_0001, 5'd1);
    repeat (2) @(negedge clock);
    op = SLL; data_in = 32'hFFFF_FFFF; shift_amt = 5'd8; ctrl_start = 1'b1;
    @(negedge clock);
    ctrl_start = 1'b0;
    wait_rdy(3, n);
    chk("ignore latency", n, exp_lat(5'd1));
    chk("ignore result", data_result, 32'h0000_0003);
    @(negedge clock);
    chk("ignore no queue", {31'd0, busy}, 32'd0);
    chk("ignore rdy pulse", {31'd0, data_resultRDY}, 32'd0);
    // start in the RDY cycle is accepted
    kick(SRL, 32'h8000_00F0, 5'd4);
    wait_rdy(0, n);
    chk("b2b first", data_result, 32'h0800_000F);
    op = SLL; data_in = 32'h0000_00FF; shift_amt = 5'd8; ctrl_start = 1'b1;
    @(negedge clock);
    ctrl_start = 1'b0; data_in = '0;
    chk("b2b rdy fall", {31'd0, data_resultRDY}, 32'd0);
    chk("b2b busy", {31'd0, busy}, 32'd1);
    chk("b2b hold", data_result, 32'h0800_000F);
    wait_rdy(0, n);
    chk("b2b latency", n, exp_lat(5'd8));
    chk("b2b second", data_result, 32'h0000_FF00);
    // asynchronous abort mid-operation
    kick(SLL, 32'h1234_5678, 5'd5);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort result", data_result, 32'h0);
    chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    chk("abort no rdy", seen, 0);
    do_op("post abort", SLL, 32'h1234_5678, 5'd5, 32'h468A_CF00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
